// File: rtl/mul_issue_queue_pkg.sv
// Shared definitions for the MUL/ALU issue queue: flag indices, opcodes and the request record.
package mul_issue_queue_pkg;

    localparam int FLAG_Z = 0;
    localparam int FLAG_S = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    localparam int REQ_OP_W   = 3;
    localparam int REQ_DATA_W = 8;
    localparam int REQ_DEST_W = 3;

    // The queue never decodes these; they only travel to the functional unit.
    localparam logic [REQ_OP_W-1:0] OP_ADD = 3'd0;
    localparam logic [REQ_OP_W-1:0] OP_SUB = 3'd1;
    localparam logic [REQ_OP_W-1:0] OP_MUL = 3'd2;
    localparam logic [REQ_OP_W-1:0] OP_AND = 3'd3;
    localparam logic [REQ_OP_W-1:0] OP_OR  = 3'd4;
    localparam logic [REQ_OP_W-1:0] OP_XOR = 3'd5;

    typedef struct packed {
        logic [REQ_OP_W-1:0]   op;
        logic [REQ_DATA_W-1:0] a;
        logic [REQ_DATA_W-1:0] b;
        logic [REQ_DEST_W-1:0] dest;
    } mul_req_t;

endpackage

// File: rtl/mul_issue_queue_sync_fifo.sv
// Single-clock FIFO with zeroed read data when empty; full blocks a push even if a pop happens the same cycle.
module mul_issue_queue_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rdata   = empty ? '0 : mem[rd_ptr];

    // Pointers are exactly log2(DEPTH) wide so they wrap without extra logic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (!do_push && do_pop) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/mul_issue_queue.sv
// Issue queue in front of the combinational MUL/ALU unit with a registered writeback slot.
// Optional writeback statistics are enabled by defining MUL_ISSUE_STATS_EN.
module mul_issue_queue
    import mul_issue_queue_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8,
    parameter int DEST_W = 3,
    parameter int OP_W   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OP_W-1:0]   in_op,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [DEST_W-1:0] in_dest,
    output logic [OP_W-1:0]   fu_op,
    output logic [DATA_W-1:0] fu_a,
    output logic [DATA_W-1:0] fu_b,
    input  logic [DATA_W-1:0] fu_result,
    input  logic [3:0]        fu_flags,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic [DEST_W-1:0] wb_dest,
    output logic [DATA_W-1:0] wb_result,
    output logic [3:0]        wb_flags
`ifdef MUL_ISSUE_STATS_EN
    ,
    output logic [15:0]       stat_ops,
    output logic [15:0]       stat_carry
`endif
);
    // Handshakes: a transfer happens on a rising edge where valid && ready; valid never
    // waits on ready, and the sender holds its payload stable until the transfer.
    localparam int REQ_W = OP_W + 2 * DATA_W + DEST_W;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [REQ_W-1:0]  head;
    logic [CNT_W-1:0]  q_count;
    logic              q_empty;
    logic [DEST_W-1:0] head_dest;
    logic              cap;

    assign in_ready = (q_count != CNT_W'(DEPTH));
    assign cap      = !q_empty && (!wb_valid || wb_ready);
    assign {fu_op, fu_a, fu_b, head_dest} = head;

    mul_issue_queue_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (REQ_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (in_valid),
        .pop   (cap),
        .wdata ({in_op, in_a, in_b, in_dest}),
        .rdata (head),
        .empty (q_empty),
        .count (q_count)
    );

    // The unit is combinational from the head, so its result is captured the same cycle the head pops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_valid  <= 1'b0;
            wb_dest   <= '0;
            wb_result <= '0;
            wb_flags  <= '0;
        end else if (cap) begin
            wb_valid  <= 1'b1;
            wb_dest   <= head_dest;
            wb_result <= fu_result;
            wb_flags  <= fu_flags;
        end else if (wb_valid && wb_ready) begin
            wb_valid  <= 1'b0;
        end
    end

`ifdef MUL_ISSUE_STATS_EN
    // Both counters stick at all-ones rather than wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_ops   <= '0;
            stat_carry <= '0;
        end else if (wb_valid && wb_ready) begin
            if (stat_ops != 16'hFFFF) stat_ops <= stat_ops + 16'd1;
            if (wb_flags[FLAG_C] && stat_carry != 16'hFFFF) stat_carry <= stat_carry + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mul_issue_queue.sv
// Bench for mul_issue_queue: directed steps plus random traffic against a transaction-level model.
module tb_mul_issue_queue;
    import mul_issue_queue_pkg::*;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [2:0] in_op = '0;
    logic [7:0] in_a = '0;
    logic [7:0] in_b = '0;
    logic [2:0] in_dest = '0;
    logic [2:0] fu_op;
    logic [7:0] fu_a;
    logic [7:0] fu_b;
    logic [7:0] fu_result;
    logic [3:0] fu_flags;
    logic       wb_valid;
    logic       wb_ready = 1'b0;
    logic [2:0] wb_dest;
    logic [7:0] wb_result;
    logic [3:0] wb_flags;
`ifdef MUL_ISSUE_STATS_EN
    logic [15:0] stat_ops;
    logic [15:0] stat_carry;
    int          stat_ops_m = 0;
    int          stat_carry_m = 0;
`endif

    int checks = 0;
    int errors = 0;

    // Model state: requests in flight in push order (slot entry first when the slot is full).
    logic [33:0] exp_q[$];
    int          cnt_m = 0;
    logic        wbv_m = 1'b0;

    always #5 clk = ~clk;

    mul_issue_queue dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_a(in_a), .in_b(in_b), .in_dest(in_dest),
        .fu_op(fu_op), .fu_a(fu_a), .fu_b(fu_b),
        .fu_result(fu_result), .fu_flags(fu_flags),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_dest(wb_dest),
        .wb_result(wb_result), .wb_flags(wb_flags)
`ifdef MUL_ISSUE_STATS_EN
        , .stat_ops(stat_ops), .stat_carry(stat_carry)
`endif
    );

    // Functional unit reference: returns {V,C,S,Z, result}.
    function automatic logic [11:0] alu_ref(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        logic [8:0]  s;
        logic [7:0]  r;
        logic        c;
        logic        v;
        p = 16'(a) * 16'(b);
        s = '0;
        r = '0;
        c = 1'b0;
        v = 1'b0;
        case (op)
            OP_ADD: begin s = {1'b0, a} + {1'b0, b}; r = s[7:0]; c = s[8]; v = (a[7] == b[7]) && (r[7] != a[7]); end
            OP_SUB: begin s = {1'b0, a} - {1'b0, b}; r = s[7:0]; c = s[8]; v = (a[7] != b[7]) && (r[7] != a[7]); end
            OP_MUL: begin r = p[7:0]; c = |p[15:8]; end
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            default: r = '0;
        endcase
        return {v, c, r[7], (r == 8'h00), r};
    endfunction

    always_comb {fu_flags, fu_result} = alu_ref(fu_op, fu_a, fu_b);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: compare against the model at the falling edge, advance the model, return just after the rising edge.
    task automatic tick();
        logic [33:0] e;
        logic        push_m;
        logic        cap_m;
        int          hi;
        @(negedge clk);
        check("in_ready", 32'(in_ready), 32'(cnt_m != DEPTH));
        check("wb_valid", 32'(wb_valid), 32'(wbv_m));
        hi = wbv_m ? 1 : 0;
        if (cnt_m == 0) begin
            check("fu_idle", {8'h0, 5'h0, fu_op, fu_a, fu_b}, 32'h0);
        end else begin
            e = exp_q[hi];
            check("fu_head", {13'h0, fu_op, fu_a, fu_b}, {13'h0, e[33:31], e[30:23], e[22:15]});
        end
        if (wbv_m && wb_ready) begin
            e = exp_q.pop_front();
            check("wb_data", {17'h0, wb_dest, wb_flags, wb_result}, {17'h0, e[14:12], e[11:0]});
`ifdef MUL_ISSUE_STATS_EN
            if (stat_ops_m < 16'hFFFF) stat_ops_m++;
            if (e[8 + FLAG_C] && stat_carry_m < 16'hFFFF) stat_carry_m++;
`endif
        end
        push_m = in_valid && (cnt_m != DEPTH);
        cap_m  = (cnt_m != 0) && (!wbv_m || wb_ready);
        if (push_m) exp_q.push_back({in_op, in_a, in_b, in_dest, alu_ref(in_op, in_a, in_b)});
        cnt_m = cnt_m + int'(push_m) - int'(cap_m);
        wbv_m = cap_m || (wbv_m && !wb_ready);
        @(posedge clk);
        #1;
`ifdef MUL_ISSUE_STATS_EN
        check("stat_ops", 32'(stat_ops), 32'(stat_ops_m));
        check("stat_carry", 32'(stat_carry), 32'(stat_carry_m));
`endif
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic [2:0] d);
        in_valid = v;
        in_op    = op;
        in_a     = a;
        in_b     = b;
        in_dest  = d;
    endtask

    task automatic model_reset();
        exp_q.delete();
        cnt_m = 0;
        wbv_m = 1'b0;
`ifdef MUL_ISSUE_STATS_EN
        stat_ops_m   = 0;
        stat_carry_m = 0;
`endif
    endtask

    task automatic drain();
        in_valid = 1'b0;
        wb_ready = 1'b1;
        for (int i = 0; i < DEPTH + 3; i++) tick();
        check("drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        // Clock/reset
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", {20'h0, in_ready, wb_valid, wb_dest, wb_flags, wb_result[2:0]}, 32'h800);
        check("rst_wb_result", 32'(wb_result), 32'h0);
        check("rst_fu", {8'h0, 5'h0, fu_op, fu_a, fu_b}, 32'h0);
        rst = 1'b0;

        // MUL 5*6 -> 0x1E, captured one edge after the push edge
        wb_ready = 1'b1;
        drive(1'b1, OP_MUL, 8'd5, 8'd6, 3'd2);
        tick();
        in_valid = 1'b0;
        tick();
        check("mul_5x6_valid", 32'(wb_valid), 32'd1);
        check("mul_5x6", {20'h0, wb_dest, wb_flags, wb_result}, {20'h0, 3'd2, 4'b0000, 8'h1E});

        // MUL 16*16 -> 0x00 with Z and C
        drive(1'b1, OP_MUL, 8'd16, 8'd16, 3'd5);
        tick();
        in_valid = 1'b0;
        tick();
        check("mul_16x16", {20'h0, wb_dest, wb_flags, wb_result}, {20'h0, 3'd5, 4'b0101, 8'h00});
        tick();

        // Backpressure: six pushes, five fit (DEPTH + slot)
        wb_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, OP_ADD, 8'(i + 1), 8'd3, 3'(i));
            tick();
        end
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_accepted", 32'(exp_q.size()), 32'd5);
        drain();

        // Steady occupancy of two with simultaneous push and pop across pointer wrap
        wb_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, OP_SUB, 8'(10 * i), 8'd7, 3'(i));
            tick();
        end
        wb_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, OP_MUL, 8'(20 + i), 8'(i + 1), 3'(i));
            tick();
            check("steady_in_ready", 32'(in_ready), 32'd1);
        end
        check("steady_depth", 32'(exp_q.size()), 32'd3);
        drain();

        // Asynchronous reset with three queued and the slot full
        wb_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, OP_XOR, 8'hA0 + 8'(i), 8'h0F, 3'(i + 4));
            tick();
        end
        check("pre_rst_valid", 32'(wb_valid), 32'd1);
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("async_rst", {29'h0, wb_valid, in_ready, 1'b0}, 32'b010);
        check("async_rst_fu", {8'h0, 5'h0, fu_op, fu_a, fu_b}, 32'h0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        wb_ready = 1'b1;
        repeat (3) tick();
        drive(1'b1, OP_OR, 8'h12, 8'h40, 3'd7);
        tick();
        drain();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            drive(1'($urandom_range(0, 1)), 3'($urandom_range(0, 5)), 8'($urandom), 8'($urandom), 3'($urandom));
            wb_ready = ($urandom_range(0, 9) < 7);
            tick();
        end
        drain();

`ifdef MUL_ISSUE_STATS_EN
        // Three completions, one carrying; then saturation
        rst = 1'b1;
        #1;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        drive(1'b1, OP_ADD, 8'd200, 8'd100, 3'd1);
        tick();
        drive(1'b1, OP_ADD, 8'd1, 8'd2, 3'd2);
        tick();
        drive(1'b1, OP_MUL, 8'd2, 8'd3, 3'd3);
        tick();
        drain();
        check("stat_ops_3", 32'(stat_ops), 32'd3);
        check("stat_carry_1", 32'(stat_carry), 32'd1);
        force dut.stat_ops = 16'hFFFF;
        #1;
        release dut.stat_ops;
        stat_ops_m = 16'hFFFF;
        drive(1'b1, OP_AND, 8'hFF, 8'h0F, 3'd4);
        tick();
        drain();
        check("stat_ops_sat", 32'(stat_ops), 32'hFFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
